// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit and its funct3 decoder.
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FAULT, S_REQ, S_WAIT} state_t;
  localparam logic [3:0] SM_BYTE   = 4'b0001;
  localparam logic [3:0] SM_BYTE_S = 4'b1001;
  localparam logic [3:0] SM_HALF   = 4'b0011;
  localparam logic [3:0] SM_HALF_S = 4'b1011;
  localparam logic [3:0] SM_WORD   = 4'b0111;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;
endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: maps funct3/store/address to data_mem sign_mask and fault flags.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       illegal,
  output logic       misaligned
);
  // A zero mask marks an encoding with no defined width.
  assign sign_mask = funct3 == F3_B ? (store ? SM_BYTE : SM_BYTE_S) :
                     funct3 == F3_H ? (store ? SM_HALF : SM_HALF_S) :
                     funct3 == F3_W ? SM_WORD :
                     (!store && funct3 == F3_BU) ? SM_BYTE :
                     (!store && funct3 == F3_HU) ? SM_HALF : 4'b0000;
  assign illegal    = sign_mask == 4'b0000;
  assign misaligned = (sign_mask[2:0] == 3'b011 && addr_lo[0]) ||
                      (sign_mask[2:0] == 3'b111 && addr_lo != 2'b00);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage bridge to data_mem with alignment checks,
// single-cycle strobes, stall tolerance and timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        busy,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_memwrite,
  output logic        dm_memread,
  output logic [3:0]  dm_sign_mask,
  input  logic [31:0] dm_read_data,
  input  logic        dm_clk_stall
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          store_q;
  logic [1:0]    fault_q;
  logic [3:0]    sign_mask;
  logic          illegal, misaligned;
  lsu_decode u_decode (
    .store      (req_store),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .sign_mask  (sign_mask),
    .illegal    (illegal),
    .misaligned (misaligned)
  );
  assign busy        = state != S_IDLE;
  assign req_ready   = !busy;
  assign dm_memread  = state == S_REQ && !store_q;
  assign dm_memwrite = state == S_REQ && store_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      store_q       <= 1'b0;
      fault_q       <= FLT_OK;
      dm_addr       <= '0;
      dm_write_data <= '0;
      dm_sign_mask  <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_fault    <= FLT_OK;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          store_q       <= req_store;
          dm_addr       <= req_addr;
          dm_write_data <= req_wdata;
          dm_sign_mask  <= sign_mask;
          fault_q       <= illegal ? FLT_ILLEGAL : misaligned ? FLT_MISALIGN : FLT_OK;
          state         <= (illegal || misaligned) ? S_FAULT : S_REQ;
        end
        S_FAULT: begin
          resp_valid <= 1'b1;
          resp_fault <= fault_q;
          resp_rdata <= '0;
          state      <= S_IDLE;
        end
        S_REQ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion wins over timeout when both land on the same cycle.
          if (cnt >= MIN_LAST && !dm_clk_stall) begin
            resp_valid <= 1'b1;
            resp_fault <= FLT_OK;
            resp_rdata <= store_q ? 32'h0 : dm_read_data;
            state      <= S_IDLE;
          end else if (cnt >= TO_LAST) begin
            resp_valid <= 1'b1;
            resp_fault <= FLT_TIMEOUT;
            resp_rdata <= '0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scenario tasks with inline checks plus a response scoreboard.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, busy, dm_memwrite, dm_memread;
  logic [31:0] resp_rdata, dm_addr, dm_write_data;
  logic [1:0]  resp_fault;
  logic [3:0]  dm_sign_mask;
  logic [31:0] dm_read_data = '0;
  logic        dm_clk_stall = 1'b0;
  typedef struct packed {logic [31:0] rdata; logic [1:0] fault;} exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  load_store_unit #(.MIN_WAIT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .busy(busy), .dm_addr(dm_addr),
    .dm_write_data(dm_write_data), .dm_memwrite(dm_memwrite),
    .dm_memread(dm_memread), .dm_sign_mask(dm_sign_mask),
    .dm_read_data(dm_read_data), .dm_clk_stall(dm_clk_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: resp_valid with rdata=%h fault=%b, no response expected", resp_rdata, resp_fault);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (resp_rdata !== e.rdata || resp_fault !== e.fault) begin
          n_fail++;
          $display("FAIL sb_resp: got rdata=%h fault=%b, expected rdata=%h fault=%b", resp_rdata, resp_fault, e.rdata, e.fault);
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accept edge (REQ/FAULT cycle).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic [1:0] ef);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    exp_q.push_back('{er, ef});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({req_ready, busy, resp_valid, dm_memread, dm_memwrite} !== 5'b10000 ||
        dm_addr !== 0 || dm_write_data !== 0 || dm_sign_mask !== 0 || resp_rdata !== 0 || resp_fault !== 0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b busy=%b rv=%b rd=%b wr=%b addr=%h wd=%h sm=%b expected ready=1, rest 0",
               req_ready, busy, resp_valid, dm_memread, dm_memwrite, dm_addr, dm_write_data, dm_sign_mask);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    dm_read_data = 32'hdeadbeef;
    issue(1'b1, 3'b010, 32'h4, 32'hff03ab21, 32'h0, 2'b00);
    n_checks++;
    if (dm_memwrite !== 1 || dm_memread !== 0 || dm_sign_mask !== 4'b0111 || dm_addr !== 32'h4 ||
        dm_write_data !== 32'hff03ab21 || busy !== 1) begin
      n_fail++;
      $display("FAIL sw_req: wr=%b rd=%b sm=%b addr=%h wd=%h busy=%b expected wr=1 rd=0 sm=0111 addr=4 wd=ff03ab21 busy=1",
               dm_memwrite, dm_memread, dm_sign_mask, dm_addr, dm_write_data, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dm_memwrite !== 0 || busy !== 1 || resp_valid !== 0 || dm_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL sw_wait: wr=%b busy=%b rv=%b addr=%h expected 0 1 0 4", dm_memwrite, busy, resp_valid, dm_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL sw_resp_timing: rv=%b busy=%b expected rv=1 busy=0", resp_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 0) begin
      n_fail++;
      $display("FAIL sw_pulse: resp_valid=%b expected 0 one cycle after response", resp_valid);
    end
  endtask

  task automatic test_load_half();
    logic [2:0]  f3[2] = '{3'b001, 3'b101};
    logic [3:0]  sm[2] = '{4'b1011, 4'b0011};
    logic [31:0] rd[2] = '{32'hffffab21, 32'h0000ab21};
    for (int i = 0; i < 2; i++) begin
      dm_read_data = rd[i];
      issue(1'b0, f3[i], 32'h8, 32'h0, rd[i], 2'b00);
      n_checks++;
      if (dm_memread !== 1 || dm_memwrite !== 0 || dm_sign_mask !== sm[i]) begin
        n_fail++;
        $display("FAIL half_req%0d: rd=%b wr=%b sm=%b expected rd=1 wr=0 sm=%b", i, dm_memread, dm_memwrite, dm_sign_mask, sm[i]);
      end
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (resp_valid !== 1) begin
        n_fail++;
        $display("FAIL half_resp_timing%0d: resp_valid=%b expected 1", i, resp_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_byte();
    int strobes = 0;
    dm_clk_stall = 1'b1;
    dm_read_data = 32'hffffff80;
    issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hffffff80, 2'b00);
    n_checks++;
    if (dm_memread !== 1 || dm_sign_mask !== 4'b1001) begin
      n_fail++;
      $display("FAIL lb_req: rd=%b sm=%b expected rd=1 sm=1001", dm_memread, dm_sign_mask);
    end
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 7) dm_clk_stall = 1'b0;
      strobes += int'(dm_memread);
      n_checks++;
      if (resp_valid !== (c == 8) || dm_addr !== 32'h13 || dm_sign_mask !== 4'b1001) begin
        n_fail++;
        $display("FAIL lb_stall_c%0d: rv=%b addr=%h sm=%b expected rv=%b addr=13 sm=1001", c, resp_valid, dm_addr, dm_sign_mask, c == 8);
      end
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL lb_single_strobe: %0d extra memread cycles, expected 0", strobes);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_faults();
    logic        st[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3[4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] ad[4] = '{32'h6, 32'h6, 32'h1, 32'h9};
    logic [1:0]  fc[4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      issue(st[i], f3[i], ad[i], 32'h55, 32'h0, fc[i]);
      n_checks++;
      if (dm_memread !== 0 || dm_memwrite !== 0 || busy !== 1) begin
        n_fail++;
        $display("FAIL fault_nostrobe%0d: rd=%b wr=%b busy=%b expected 0 0 1", i, dm_memread, dm_memwrite, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1 || dm_memread !== 0 || dm_memwrite !== 0) begin
        n_fail++;
        $display("FAIL fault_timing%0d: rv=%b rd=%b wr=%b expected rv=1 rd=0 wr=0", i, resp_valid, dm_memread, dm_memwrite);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    dm_clk_stall = 1'b1;
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 2'b11);
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== (c == 10) || busy !== (c != 10)) begin
        n_fail++;
        $display("FAIL timeout_c%0d: rv=%b busy=%b expected rv=%b busy=%b", c, resp_valid, busy, c == 10, c != 10);
      end
    end
    dm_clk_stall = 1'b0;
    dm_read_data = 32'h12345678;
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 32'h24, 32'h0, 32'h12345678, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (resp_valid !== 1) begin
      n_fail++;
      $display("FAIL timeout_recover: resp_valid=%b expected 1", resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    dm_read_data = 32'hcafef00d;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hcafef00d, 2'b00);
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (resp_valid !== 1 || req_ready !== 1) begin
      n_fail++;
      $display("FAIL b2b_resp_cycle: rv=%b ready=%b expected 1 1", resp_valid, req_ready);
    end
    dm_read_data = 32'h000000a5;
    issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000a5, 2'b00);
    n_checks++;
    if (dm_memread !== 1 || dm_addr !== 32'h11 || dm_sign_mask !== 4'b0001) begin
      n_fail++;
      $display("FAIL b2b_zero_bubble: rd=%b addr=%h sm=%b expected rd=1 addr=11 sm=0001", dm_memread, dm_addr, dm_sign_mask);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (resp_valid !== 1) begin
      n_fail++;
      $display("FAIL b2b_second_resp: resp_valid=%b expected 1", resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      dm_clk_stall = 1'b1;
      issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 2'b00);
      void'(exp_q.pop_back());
      repeat (2 * k) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 0 || dm_memread !== 0 || dm_memwrite !== 0 || resp_valid !== 0 || req_ready !== 1) begin
        n_fail++;
        $display("FAIL reset_mid%0d: busy=%b rd=%b wr=%b rv=%b ready=%b expected 0 0 0 0 1",
                 k, busy, dm_memread, dm_memwrite, resp_valid, req_ready);
      end
      dm_clk_stall = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      n_checks++;
      if (req_ready !== 1 || busy !== 0) begin
        n_fail++;
        $display("FAIL reset_release%0d: ready=%b busy=%b expected 1 0", k, req_ready, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_half();
    test_stall_byte();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I MEM pipeline stage and data_mem.
- Accepts one load/store request per handshake and decodes funct3 into data_mem's sign_mask encoding.
- Checks alignment, issues a single-cycle memread/memwrite strobe and rides out data_mem's clk_stall.
- Returns the load result with a one-cycle response pulse, asserting busy to stall the pipeline while an access is in flight.

Parameters:
- MIN_WAIT, 1: minimum WAIT cycles before clk_stall is trusted as the completion indicator (must be ≥1).
- TIMEOUT, 64: WAIT cycles after which the access is abandoned with a timeout fault.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  unit can accept (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result (already extended by data_mem); 0 for stores/faults.
- resp_fault  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- busy  out  1  pipeline stall; high whenever state != IDLE.
- dm_addr  out  32  to data_mem addr.
- dm_write_data  out  32  to data_mem write_data.
- dm_memwrite  out  1  to data_mem memwrite.
- dm_memread  out  1  to data_mem memread.
- dm_sign_mask  out  4  to data_mem sign_mask.
- dm_read_data  in  32  from data_mem read_data.
- dm_clk_stall  in  1  from data_mem clk_stall.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0 except req_ready=1; request registers cleared; wait counter 0.
- Reset mid-access: strobes drop immediately, no resp_valid is produced, and the access is lost.
- sign_mask: bit3 = sign-extend, bits[2:0] = width (001 byte, 011 half, 111 word).
- funct3 decode, loads: 000→1001, 001→1011, 010→0111, 100→0001, 101→0011.
- funct3 decode, stores: 000→0001, 001→0011, 010→0111.
- Illegal funct3: loads 011/110/111; stores anything else.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Bytes are never misaligned.
- Handshake: accept when req_valid && req_ready; latch store, sign_mask, addr and wdata.
- States: IDLE, FAULT, REQ, WAIT.
- IDLE: accept. On illegal funct3 or misalignment go to FAULT; otherwise go to REQ.
- FAULT: one cycle. Next edge: resp_valid=1, resp_fault=code (illegal takes priority over misaligned), resp_rdata=0, go IDLE. data_mem is never strobed.
- REQ: exactly one cycle with dm_memread=!store or dm_memwrite=store, plus dm_addr, dm_write_data, dm_sign_mask from the latched values. Go WAIT and clear the counter.
- WAIT: strobes low; dm_addr, dm_sign_mask and dm_write_data held; counter increments each cycle.
  - When counter ≥ MIN_WAIT-1 and dm_clk_stall=0: next edge resp_valid=1, resp_rdata=dm_read_data for loads (0 for stores), resp_fault=00, go IDLE.
  - dm_clk_stall=1 keeps the unit in WAIT.
  - If the counter reaches TIMEOUT-1 with stall still high: resp_valid with fault 11, rdata 0, go IDLE.
- Latency: request accepted at edge N, no stall, MIN_WAIT=1 → strobe during cycle N+1, resp_valid during cycle N+3. Each stalled cycle adds one.
- resp_valid is a single-cycle pulse. resp_rdata and resp_fault hold their values until the next response.
- Back-to-back: the unit is in IDLE in the resp_valid cycle, so a new request may be accepted in that same cycle.
- busy = (state != IDLE); req_ready = !busy.
- dm_* address/data outputs hold their last values in IDLE. Strobes are never high outside REQ.

Decomposition:
- Shared package/header lsu_pkg holds:
  - state encodings;
  - sign_mask constants (SM_BYTE, SM_BYTE_S, SM_HALF, SM_HALF_S, SM_WORD);
  - RV32I load/store funct3 constants;
  - fault code constants.
- One sub-module, lsu_decode: combinational funct3/store/addr → sign_mask, illegal, misaligned.
- FSM, counter and response registers live in load_store_unit.

Test Plan:
- SW: addr 0x4, wdata 0xff03ab21, funct3 010, no stall → REQ cycle with memwrite=1, sign_mask 0111. resp_valid 2 cycles later, fault 00, busy high for 2 cycles.
- LH then LHU at addr 0x8 with memory half 0xab21 → sign_mask 1011 / 0011; resp_rdata 0xffffab21 / 0x0000ab21.
- LB at addr 0x13 with dm_clk_stall held high 5 WAIT cycles → memread pulses once (sign_mask 1001). resp_valid exactly 5 cycles later than the no-stall case; dm_addr stays 0x13 throughout.
- LW at addr 0x6 → no strobe; resp_valid 2 cycles after accept with fault 01. funct3 011 load → fault 10.
- Stall held permanently with TIMEOUT=8 → resp fault 11 after 8 WAIT cycles; unit returns to IDLE, and the next request completes normally.
- rst_n low during WAIT → busy, strobes and resp_valid go 0 immediately. After release, req_ready=1 and no spurious resp_valid. A request issued in the resp_valid cycle is accepted with zero bubble.
